// File: rtl/dtlb_micro_cache_if.sv
// Bundles the EX request, main-TLB query and data-bus request signals of the data micro-TLB.
// master is the surrounding pipeline/bus side; slave is the micro-TLB itself.
interface dtlb_micro_cache_if;
    logic        flush;
    logic        req_valid;
    logic        req_wr;
    logic [31:0] req_vaddr;
    logic [31:0] tlb_vaddr;
    logic [31:0] tlb_paddr;
    logic        tlb_miss;
    logic        tlb_invalid;
    logic        tlb_dirty;
    logic        mem_req;
    logic [31:0] mem_paddr;
    logic        mem_addr_ok;
    logic        exc;
    logic [4:0]  exc_code;
    logic        exc_refill;
    logic        done;

    modport master (
        output flush, req_valid, req_wr, req_vaddr, tlb_paddr, tlb_miss, tlb_invalid, tlb_dirty,
               mem_addr_ok,
        input  tlb_vaddr, mem_req, mem_paddr, exc, exc_code, exc_refill, done
    );

    modport slave (
        input  flush, req_valid, req_wr, req_vaddr, tlb_paddr, tlb_miss, tlb_invalid, tlb_dirty,
               mem_addr_ok,
        output tlb_vaddr, mem_req, mem_paddr, exc, exc_code, exc_refill, done
    );
endinterface

// File: rtl/dtlb_micro_cache.sv
// Data-side micro-TLB: caches main-TLB results (including faults) for EX loads/stores,
// refills round-robin on a lookup miss and drives the data-bus request.
module dtlb_micro_cache #(
    parameter int unsigned ENTRIES     = 4,
    parameter int unsigned PAGE_BITS   = 12,
    parameter bit          KSEG_BYPASS = 1'b1
) (
    input logic               clk,
    input logic               resetn,
    dtlb_micro_cache_if.slave io_bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned VPN_W = 32 - PAGE_BITS;

    typedef enum logic [1:0] {StCheck, StQuery, StReq} state_e;

    state_e             r_state;
    logic [ENTRIES-1:0] r_valid;
    logic [VPN_W-1:0]   r_vpn [ENTRIES];
    logic [VPN_W-1:0]   r_ppn [ENTRIES];
    logic [ENTRIES-1:0] r_miss;
    logic [ENTRIES-1:0] r_inv;
    logic [ENTRIES-1:0] r_dirty;
    logic [IDX_W-1:0]   r_rr;
    logic [31:0]        r_tlb_vaddr;
    logic [VPN_W-1:0]   r_fill_ppn;
    logic               r_fill_miss;
    logic               r_fill_inv;
    logic               r_fill_dirty;

    logic [VPN_W-1:0] w_vpn;
    logic             w_hit;
    logic [VPN_W-1:0] w_hit_ppn;
    logic             w_hit_miss, w_hit_inv, w_hit_dirty;
    logic             w_bypass, w_eval, w_byp_req, w_lookup_miss;
    logic [VPN_W-1:0] w_src_ppn;
    logic             w_src_miss, w_src_inv, w_src_dirty;
    logic             w_fault, w_exc, w_mem_req;
    logic             w_unused_paddr;

    assign w_vpn          = io_bus.req_vaddr[31:PAGE_BITS];
    assign w_unused_paddr = ^io_bus.tlb_paddr[PAGE_BITS-1:0];

    // At most one entry can match, so OR-merging the matching fields is a clean select.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_ppn   = '0;
        w_hit_miss  = 1'b0;
        w_hit_inv   = 1'b0;
        w_hit_dirty = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_vpn[i] == w_vpn)) begin
                w_hit       = 1'b1;
                w_hit_ppn   = w_hit_ppn | r_ppn[i];
                w_hit_miss  = w_hit_miss | r_miss[i];
                w_hit_inv   = w_hit_inv | r_inv[i];
                w_hit_dirty = w_hit_dirty | r_dirty[i];
            end
        end
        if (io_bus.flush) begin
            w_hit = 1'b0;
        end
    end

    assign w_bypass      = KSEG_BYPASS && (io_bus.req_vaddr[31:30] == 2'b10);
    assign w_byp_req     = io_bus.req_valid && (r_state == StCheck) && w_bypass;
    assign w_lookup_miss = io_bus.req_valid && (r_state == StCheck) && !w_bypass && !w_hit;
    assign w_eval        = io_bus.req_valid &&
                           ((r_state == StReq) || ((r_state == StCheck) && !w_bypass && w_hit));

    assign w_src_ppn   = (r_state == StReq) ? r_fill_ppn   : w_hit_ppn;
    assign w_src_miss  = (r_state == StReq) ? r_fill_miss  : w_hit_miss;
    assign w_src_inv   = (r_state == StReq) ? r_fill_inv   : w_hit_inv;
    assign w_src_dirty = (r_state == StReq) ? r_fill_dirty : w_hit_dirty;

    assign w_fault   = w_src_miss | w_src_inv;
    assign w_exc     = w_eval && (w_fault || (io_bus.req_wr && !w_src_dirty));
    assign w_mem_req = w_byp_req || (w_eval && !w_exc);

    always_comb begin
        io_bus.mem_paddr = '0;
        if (w_byp_req) begin
            io_bus.mem_paddr = io_bus.req_vaddr;
        end else if (w_mem_req) begin
            io_bus.mem_paddr = {w_src_ppn, io_bus.req_vaddr[PAGE_BITS-1:0]};
        end
    end

    always_comb begin
        io_bus.exc_code = 5'd0;
        if (w_exc) begin
            if (w_fault) begin
                io_bus.exc_code = io_bus.req_wr ? 5'd3 : 5'd2;
            end else begin
                io_bus.exc_code = 5'd1;
            end
        end
    end

    assign io_bus.mem_req    = w_mem_req;
    assign io_bus.exc        = w_exc;
    assign io_bus.exc_refill = w_exc && w_src_miss;
    assign io_bus.done       = (w_mem_req && io_bus.mem_addr_ok) || w_exc;
    assign io_bus.tlb_vaddr  = r_tlb_vaddr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= StCheck;
            r_valid      <= '0;
            r_rr         <= '0;
            r_tlb_vaddr  <= '0;
            r_fill_ppn   <= '0;
            r_fill_miss  <= 1'b0;
            r_fill_inv   <= 1'b0;
            r_fill_dirty <= 1'b0;
        end else begin
            unique case (r_state)
                StCheck: begin
                    if (w_lookup_miss) begin
                        r_tlb_vaddr <= io_bus.req_vaddr;
                        r_state     <= StQuery;
                    end
                end
                StQuery: begin
                    // A flush here drops the fill so the lookup repeats against the new TLB.
                    if (io_bus.flush) begin
                        r_state <= StCheck;
                    end else begin
                        r_vpn[r_rr]   <= r_tlb_vaddr[31:PAGE_BITS];
                        r_ppn[r_rr]   <= io_bus.tlb_paddr[31:PAGE_BITS];
                        r_miss[r_rr]  <= io_bus.tlb_miss;
                        r_inv[r_rr]   <= io_bus.tlb_invalid;
                        r_dirty[r_rr] <= io_bus.tlb_dirty;
                        r_valid[r_rr] <= 1'b1;
                        r_rr          <= r_rr + IDX_W'(1);
                        r_fill_ppn    <= io_bus.tlb_paddr[31:PAGE_BITS];
                        r_fill_miss   <= io_bus.tlb_miss;
                        r_fill_inv    <= io_bus.tlb_invalid;
                        r_fill_dirty  <= io_bus.tlb_dirty;
                        r_state       <= StReq;
                    end
                end
                StReq: begin
                    if (w_exc || io_bus.mem_addr_ok || !io_bus.req_valid) begin
                        r_state <= StCheck;
                    end
                end
                default: r_state <= StCheck;
            endcase
            if (io_bus.flush) begin
                r_valid <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dtlb_micro_cache.sv
// Directed self-checking bench for the data micro-TLB: bypass, hit/miss latency, fault codes,
// round-robin eviction, flush handling and request cancellation.
module tb_dtlb_micro_cache;
    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    dtlb_micro_cache_if u_if ();

    dtlb_micro_cache #(
        .ENTRIES    (4),
        .PAGE_BITS  (12),
        .KSEG_BYPASS(1'b1)
    ) u_dut (
        .clk   (clk),
        .resetn(resetn),
        .io_bus(u_if.slave)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tlb(input logic [31:0] pa, input logic m, input logic inv, input logic d);
        u_if.tlb_paddr   = pa;
        u_if.tlb_miss    = m;
        u_if.tlb_invalid = inv;
        u_if.tlb_dirty   = d;
    endtask

    task automatic drive(input logic wr, input logic [31:0] va, input logic ok);
        u_if.req_valid   = 1'b1;
        u_if.req_wr      = wr;
        u_if.req_vaddr   = va;
        u_if.mem_addr_ok = ok;
    endtask

    task automatic release_req();
        u_if.req_valid   = 1'b0;
        u_if.mem_addr_ok = 1'b0;
    endtask

    task automatic flush_pulse();
        u_if.flush = 1'b1;
        step();
        u_if.flush = 1'b0;
    endtask

    // One complete op with the bus accepting at once; exp_query selects the 2-cycle miss path.
    task automatic do_op(input string tag, input logic wr, input logic [31:0] va,
                         input logic exp_query, input logic exp_exc, input logic [4:0] exp_code,
                         input logic exp_refill, input logic [31:0] exp_pa);
        drive(wr, va, 1'b1);
        #1;
        if (exp_query) begin
            check_eq({tag, "/chk_mreq"}, 32'(u_if.mem_req), 32'd0);
            check_eq({tag, "/chk_done"}, 32'(u_if.done), 32'd0);
            step();
            check_eq({tag, "/tlb_vaddr"}, u_if.tlb_vaddr, va);
            check_eq({tag, "/qry_mreq"}, 32'(u_if.mem_req), 32'd0);
            check_eq({tag, "/qry_exc"}, 32'(u_if.exc), 32'd0);
            step();
        end
        check_eq({tag, "/mreq"}, 32'(u_if.mem_req), 32'(!exp_exc));
        check_eq({tag, "/exc"}, 32'(u_if.exc), 32'(exp_exc));
        check_eq({tag, "/code"}, 32'(u_if.exc_code), 32'(exp_code));
        check_eq({tag, "/refill"}, 32'(u_if.exc_refill), 32'(exp_refill));
        check_eq({tag, "/done"}, 32'(u_if.done), 32'd1);
        if (!exp_exc) begin
            check_eq({tag, "/paddr"}, u_if.mem_paddr, exp_pa);
        end
        step();
        release_req();
    endtask

    function automatic logic [31:0] va_of(input int i);
        return (32'(i) << 20) | 32'h0000_0044;
    endfunction

    function automatic logic [31:0] pa_of(input int i);
        return 32'h0A00_0000 + (32'(i) << 12);
    endfunction

    initial begin
        resetn           = 1'b0;
        u_if.flush       = 1'b0;
        u_if.req_valid   = 1'b0;
        u_if.req_wr      = 1'b0;
        u_if.req_vaddr   = '0;
        u_if.mem_addr_ok = 1'b0;
        set_tlb(32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        check_eq("rst/mreq", 32'(u_if.mem_req), 32'd0);
        check_eq("rst/exc", 32'(u_if.exc), 32'd0);
        check_eq("rst/code", 32'(u_if.exc_code), 32'd0);
        check_eq("rst/refill", 32'(u_if.exc_refill), 32'd0);
        check_eq("rst/done", 32'(u_if.done), 32'd0);
        check_eq("rst/tlb_vaddr", u_if.tlb_vaddr, 32'd0);
        resetn = 1'b1;
        step();

        // Unmapped kernel segment passes straight through with no query.
        do_op("t1_kseg", 1'b0, 32'h8000_1234, 1'b0, 1'b0, 5'd0, 1'b0, 32'h8000_1234);
        check_eq("t1/tlb_vaddr", u_if.tlb_vaddr, 32'd0);

        // Miss path with the bus stalling for two cycles.
        set_tlb(32'h1230_0000, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0040_0010, 1'b0);
        #1;
        check_eq("t2/c0_mreq", 32'(u_if.mem_req), 32'd0);
        step();
        check_eq("t2/q_tlb_vaddr", u_if.tlb_vaddr, 32'h0040_0010);
        check_eq("t2/q_mreq", 32'(u_if.mem_req), 32'd0);
        step();
        check_eq("t2/r1_mreq", 32'(u_if.mem_req), 32'd1);
        check_eq("t2/r1_paddr", u_if.mem_paddr, 32'h1230_0010);
        check_eq("t2/r1_done", 32'(u_if.done), 32'd0);
        step();
        check_eq("t2/r2_mreq", 32'(u_if.mem_req), 32'd1);
        check_eq("t2/r2_paddr", u_if.mem_paddr, 32'h1230_0010);
        check_eq("t2/r2_done", 32'(u_if.done), 32'd0);
        u_if.mem_addr_ok = 1'b1;
        #1;
        check_eq("t2/r3_done", 32'(u_if.done), 32'd1);
        step();
        release_req();
        #1;
        check_eq("t2/idle_done", 32'(u_if.done), 32'd0);
        do_op("t2_hit", 1'b0, 32'h0040_0FFC, 1'b0, 1'b0, 5'd0, 1'b0, 32'h1230_0FFC);

        // Store to a clean page: MOD from the fill, then from the cached copy.
        set_tlb(32'h2340_0000, 1'b0, 1'b0, 1'b0);
        do_op("t3_mod_q", 1'b1, 32'h0050_0000, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0);
        do_op("t3_mod_c", 1'b1, 32'h0050_0000, 1'b0, 1'b1, 5'd1, 1'b0, 32'h0);

        // Cached negative results.
        set_tlb(32'h3450_0000, 1'b1, 1'b0, 1'b0);
        do_op("t4_tlbl", 1'b0, 32'h0060_0000, 1'b1, 1'b1, 5'd2, 1'b1, 32'h0);
        do_op("t4_tlbs", 1'b1, 32'h0060_0004, 1'b0, 1'b1, 5'd3, 1'b1, 32'h0);
        set_tlb(32'h4560_0000, 1'b0, 1'b1, 1'b0);
        do_op("t4_inv", 1'b0, 32'h0070_0000, 1'b1, 1'b1, 5'd2, 1'b0, 32'h0);

        // Round-robin: five fills into four entries, the fifth evicts the first.
        flush_pulse();
        for (int i = 1; i <= 5; i++) begin
            set_tlb(pa_of(i), 1'b0, 1'b0, 1'b1);
            do_op($sformatf("t5_fill%0d", i), 1'b0, va_of(i), 1'b1, 1'b0, 5'd0, 1'b0,
                  pa_of(i) + 32'h44);
        end
        for (int i = 2; i <= 5; i++) begin
            do_op($sformatf("t5_hit%0d", i), 1'b0, va_of(i), 1'b0, 1'b0, 5'd0, 1'b0,
                  pa_of(i) + 32'h44);
        end
        set_tlb(pa_of(1), 1'b0, 1'b0, 1'b1);
        do_op("t5_evicted1", 1'b0, va_of(1), 1'b1, 1'b0, 5'd0, 1'b0, pa_of(1) + 32'h44);

        // Flush forgets cached pages.
        flush_pulse();
        set_tlb(pa_of(3), 1'b0, 1'b0, 1'b1);
        do_op("t6_flushed3", 1'b0, va_of(3), 1'b1, 1'b0, 5'd0, 1'b0, pa_of(3) + 32'h44);

        // Flush coinciding with a hit masks it.
        u_if.flush = 1'b1;
        drive(1'b0, va_of(3), 1'b1);
        #1;
        check_eq("t6/mask_mreq", 32'(u_if.mem_req), 32'd0);
        step();
        u_if.flush = 1'b0;
        step();
        check_eq("t6/mask_req_paddr", u_if.mem_paddr, pa_of(3) + 32'h44);
        step();
        release_req();

        // Flush during QUERY aborts the fill and the lookup repeats.
        set_tlb(pa_of(2), 1'b0, 1'b0, 1'b1);
        drive(1'b0, va_of(2), 1'b0);
        #1;
        step();
        check_eq("t6/fq_tlb_vaddr", u_if.tlb_vaddr, va_of(2));
        u_if.flush = 1'b1;
        step();
        u_if.flush = 1'b0;
        #1;
        check_eq("t6/fq_back_mreq", 32'(u_if.mem_req), 32'd0);
        step();
        check_eq("t6/fq_requery_mreq", 32'(u_if.mem_req), 32'd0);
        step();
        check_eq("t6/fq_req_mreq", 32'(u_if.mem_req), 32'd1);
        check_eq("t6/fq_req_paddr", u_if.mem_paddr, pa_of(2) + 32'h44);
        u_if.mem_addr_ok = 1'b1;
        #1;
        check_eq("t6/fq_done", 32'(u_if.done), 32'd1);
        step();
        release_req();

        // EX cancels while waiting in REQ: request withdrawn and lookup resumes from CHECK.
        set_tlb(pa_of(4), 1'b0, 1'b0, 1'b1);
        drive(1'b0, va_of(4), 1'b0);
        #1;
        step();
        step();
        check_eq("t6/cancel_req_mreq", 32'(u_if.mem_req), 32'd1);
        u_if.req_valid = 1'b0;
        #1;
        check_eq("t6/cancel_mreq", 32'(u_if.mem_req), 32'd0);
        check_eq("t6/cancel_exc", 32'(u_if.exc), 32'd0);
        check_eq("t6/cancel_done", 32'(u_if.done), 32'd0);
        step();
        do_op("t6_after_cancel", 1'b0, 32'h8000_0100, 1'b0, 1'b0, 5'd0, 1'b0, 32'h8000_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end
endmodule
